// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch front end: FSM state codes, BCD digit
// limits, parameter defaults and the mm:ss increment helper.
package stopwatch_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_STOP = 2'd2;
    localparam state_t ST_LAP  = 2'd3;

    localparam int SEC_TENS_MAX = 5;
    localparam int DIGIT_MAX    = 9;

    localparam int PRESCALE_DEF = 10;
    localparam int DEBOUNCE_DEF = 4;

    typedef struct packed {
        logic [3:0] m_tens;
        logic [3:0] m_ones;
        logic [2:0] s_tens;
        logic [3:0] s_ones;
    } bcd_time_t;

    // Ripple-carry increment; 99:59 wraps to 00:00 so no digit leaves its range.
    function automatic bcd_time_t bcd_inc(input bcd_time_t t);
        bcd_time_t n;
        n = t;
        if (t.s_ones != 4'(DIGIT_MAX)) begin
            n.s_ones = t.s_ones + 4'd1;
        end else begin
            n.s_ones = 4'd0;
            if (t.s_tens != 3'(SEC_TENS_MAX)) begin
                n.s_tens = t.s_tens + 3'd1;
            end else begin
                n.s_tens = 3'd0;
                if (t.m_ones != 4'(DIGIT_MAX)) begin
                    n.m_ones = t.m_ones + 4'd1;
                end else begin
                    n.m_ones = 4'd0;
                    if (t.m_tens != 4'(DIGIT_MAX)) begin
                        n.m_tens = t.m_tens + 4'd1;
                    end else begin
                        n.m_tens = 4'd0;
                    end
                end
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// Push-button input stage: 2-flop synchroniser, run-length debouncer and a
// one-cycle press pulse on the accepted level's rising edge.
module btn_debounce
    import stopwatch_ctrl_pkg::*;
#(
    parameter int DEBOUNCE = DEBOUNCE_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_press
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE - 1);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_level;
    logic       r_press;
    logic [7:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= 8'd0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= 8'd0;
            end else if (r_cnt == CNT_LAST) begin
                // Only a rising accepted level is a press; releases are silent.
                r_level <= r_sync2;
                r_press <= r_sync2;
                r_cnt   <= 8'd0;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front end: start/stop/lap/clear FSM, one-second prescaler and a
// BCD mm:ss count feeding the display multiplexer.
//
// state | meaning
// IDLE  | count 00:00, stopped
// RUN   | counting, display live
// STOP  | paused, count and partial second kept
// LAP   | counting, display shows latched count
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEF,
    parameter int DEBOUNCE = DEBOUNCE_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_btn_ss,
    input  logic       i_btn_lap,
    output logic [3:0] o_s_ones,
    output logic [2:0] o_s_tens,
    output logic [3:0] o_m_ones,
    output logic [3:0] o_m_tens,
    output logic       o_running,
    output logic       o_frozen,
    output logic       o_tick
);

    localparam logic [9:0] PRESC_LAST = 10'(PRESCALE - 1);

    logic      w_ev_ss;
    logic      w_ev_lap;
    state_t    r_state;
    state_t    w_state_nxt;
    logic      w_latch_en;
    logic      w_clear;
    logic      w_counting;
    logic      w_wrap;
    logic [9:0] r_presc;
    logic      r_tick;
    bcd_time_t r_count;
    bcd_time_t r_lap;
    bcd_time_t w_disp;

    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_ss (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_btn   (i_btn_ss),
        .o_press (w_ev_ss)
    );

    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_lap (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_btn   (i_btn_lap),
        .o_press (w_ev_lap)
    );

    assign w_counting = (r_state == ST_RUN) || (r_state == ST_LAP);
    assign w_wrap     = (r_presc == PRESC_LAST);

    // SS has priority: a coincident LAP event is dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_latch_en  = 1'b0;
        w_clear     = 1'b0;
        if (w_ev_ss) begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_RUN;
                ST_RUN:  w_state_nxt = ST_STOP;
                ST_LAP:  w_state_nxt = ST_STOP;
                ST_STOP: w_state_nxt = ST_RUN;
                default: w_state_nxt = ST_IDLE;
            endcase
        end else if (w_ev_lap) begin
            case (r_state)
                ST_RUN: begin
                    w_state_nxt = ST_LAP;
                    w_latch_en  = 1'b1;
                end
                ST_LAP:  w_state_nxt = ST_RUN;
                ST_STOP: begin
                    w_state_nxt = ST_IDLE;
                    w_clear     = 1'b1;
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_presc <= 10'd0;
            r_tick  <= 1'b0;
            r_count <= '0;
            r_lap   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= w_counting && w_wrap;
            if (w_clear) begin
                r_presc <= 10'd0;
            end else if (w_counting) begin
                r_presc <= w_wrap ? 10'd0 : r_presc + 10'd1;
            end
            // A pending tick still lands when SS stops the watch in the same cycle.
            if (w_clear) begin
                r_count <= '0;
            end else if (r_tick) begin
                r_count <= bcd_inc(r_count);
            end
            if (w_latch_en) begin
                r_lap <= r_count;
            end
        end
    end

    assign w_disp    = (r_state == ST_LAP) ? r_lap : r_count;
    assign o_s_ones  = w_disp.s_ones;
    assign o_s_tens  = w_disp.s_tens;
    assign o_m_ones  = w_disp.m_ones;
    assign o_m_tens  = w_disp.m_tens;
    assign o_running = w_counting;
    assign o_frozen  = (r_state == ST_LAP);
    assign o_tick    = r_tick;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus random button
// traffic, compared every cycle against a seconds-count reference model.
module tb_stopwatch_ctrl;

    localparam int P = 10;
    localparam int D = 4;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_STOP = 2;
    localparam int M_LAP  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_ss = 1'b0;
    logic btn_lap = 1'b0;
    logic [3:0] s_ones;
    logic [2:0] s_tens;
    logic [3:0] m_ones;
    logic [3:0] m_tens;
    logic running, frozen, tick;
    logic [17:0] dut_vec;

    int vectors = 0;
    int miscompares = 0;

    int m_secs, m_latch, m_phase, m_mode;
    bit m_tick, m_ev_ss, m_ev_lap;
    bit ss_s1, ss_s2, ss_lvl, lp_s1, lp_s2, lp_lvl;
    bit ss_hist[$];
    bit lp_hist[$];

    always #5 clk = ~clk;

    stopwatch_ctrl #(.PRESCALE(P), .DEBOUNCE(D)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_btn_ss  (btn_ss),
        .i_btn_lap (btn_lap),
        .o_s_ones  (s_ones),
        .o_s_tens  (s_tens),
        .o_m_ones  (m_ones),
        .o_m_tens  (m_tens),
        .o_running (running),
        .o_frozen  (frozen),
        .o_tick    (tick)
    );

    assign dut_vec = {m_tens, m_ones, s_tens, s_ones, running, frozen, tick};

    function automatic logic [17:0] exp_vec();
        int d;
        d = (m_mode == M_LAP) ? m_latch : m_secs;
        return {4'(d / 600), 4'((d / 60) % 10), 3'((d / 10) % 6), 4'(d % 10),
                1'(m_mode == M_RUN || m_mode == M_LAP), 1'(m_mode == M_LAP), 1'(m_tick)};
    endfunction

    task automatic model_reset();
        m_secs = 0; m_latch = 0; m_phase = 0; m_mode = M_IDLE;
        m_tick = 0; m_ev_ss = 0; m_ev_lap = 0;
        ss_s1 = 0; ss_s2 = 0; ss_lvl = 0; lp_s1 = 0; lp_s2 = 0; lp_lvl = 0;
        ss_hist.delete();
        lp_hist.delete();
    endtask

    // One clock edge of the reference behaviour, using the events visible before it.
    task automatic model_step();
        int nsecs;
        bit clr, counting, smp, ok, nss, nlp;
        counting = (m_mode == M_RUN || m_mode == M_LAP);
        clr = 0;
        nsecs = m_tick ? (m_secs + 1) % 6000 : m_secs;
        if (m_ev_ss) begin
            m_mode = (m_mode == M_IDLE || m_mode == M_STOP) ? M_RUN : M_STOP;
        end else if (m_ev_lap) begin
            if (m_mode == M_RUN) begin
                m_mode = M_LAP;
                m_latch = m_secs;
            end else if (m_mode == M_LAP) begin
                m_mode = M_RUN;
            end else if (m_mode == M_STOP) begin
                m_mode = M_IDLE;
                clr = 1;
            end
        end
        if (counting) begin
            m_tick = (m_phase == P - 1);
            m_phase = (m_phase + 1) % P;
        end else begin
            m_tick = 0;
        end
        if (clr) begin
            nsecs = 0;
            m_phase = 0;
        end
        m_secs = nsecs;

        smp = ss_s2; ss_s2 = ss_s1; ss_s1 = btn_ss;
        ss_hist.push_back(smp);
        if (ss_hist.size() > D) void'(ss_hist.pop_front());
        nss = 0;
        if (ss_hist.size() == D && smp != ss_lvl) begin
            ok = 1;
            foreach (ss_hist[i]) if (ss_hist[i] != smp) ok = 0;
            if (ok) begin ss_lvl = smp; nss = smp; end
        end

        smp = lp_s2; lp_s2 = lp_s1; lp_s1 = btn_lap;
        lp_hist.push_back(smp);
        if (lp_hist.size() > D) void'(lp_hist.pop_front());
        nlp = 0;
        if (lp_hist.size() == D && smp != lp_lvl) begin
            ok = 1;
            foreach (lp_hist[i]) if (lp_hist[i] != smp) ok = 0;
            if (ok) begin lp_lvl = smp; nlp = smp; end
        end
        m_ev_ss = nss;
        m_ev_lap = nlp;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; btn_ss = 0; btn_lap = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1; btn_ss = 0; btn_lap = 0;
        model_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if (dut_vec !== 18'd0) begin
            miscompares++;
            $display("FAIL reset_state got=%h exp=%h", dut_vec, 18'd0);
        end
        rst = 0;
        // Button already held when reset releases must still register as a press.
        @(negedge clk);
        rst = 1; btn_ss = 1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 0;
        for (int c = 0; c < 12; c++) begin
            cyc();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL reset_held c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
        end
        btn_ss = 0;
        vectors++;
        if (running !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_held_press running got=%b exp=1", running);
        end
    endtask

    task automatic test_start();
        int t_run, t_tick;
        logic [3:0] ones_after;
        do_reset();
        t_run = -1; t_tick = -1; ones_after = 4'hf;
        btn_ss = 1;
        for (int c = 0; c < 32; c++) begin
            if (c == 10) btn_ss = 0;
            cyc();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL start c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
            if (t_tick >= 0 && c == t_tick + 1) ones_after = s_ones;
            if (running && t_run < 0) t_run = c;
            if (tick && t_tick < 0) t_tick = c;
        end
        vectors++;
        if (t_run < 0 || t_tick - t_run !== P) begin
            miscompares++;
            $display("FAIL first_tick_delay got=%0d exp=%0d", t_tick - t_run, P);
        end
        vectors++;
        if (ones_after !== 4'd1) begin
            miscompares++;
            $display("FAIL first_tick_s_ones got=%0d exp=1", ones_after);
        end
    endtask

    task automatic test_lap();
        int ticks_frozen;
        logic [3:0] ones_live;
        do_reset();
        btn_ss = 1;
        for (int c = 0; c < 400 && m_secs != 5; c++) begin
            if (c == 10) btn_ss = 0;
            cyc();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL lap_wait5 c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
        end
        btn_ss = 0;
        btn_lap = 1;
        ticks_frozen = 0;
        for (int c = 0; c < 40; c++) begin
            if (c == 10) btn_lap = 0;
            cyc();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL lap_frozen c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
            if (frozen && tick) ticks_frozen++;
        end
        vectors++;
        if ({frozen, m_tens, m_ones, s_tens, s_ones} !== {1'b1, 15'd5} || ticks_frozen < 2) begin
            miscompares++;
            $display("FAIL lap_hold got=%b_%h ticks=%0d exp=1_0005 ticks>=2",
                     frozen, {m_tens, m_ones, s_tens, s_ones}, ticks_frozen);
        end
        for (int c = 0; c < 200 && m_secs != 9; c++) begin
            cyc();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL lap_wait9 c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
        end
        btn_lap = 1;
        ones_live = 4'hf;
        for (int c = 0; c < 20; c++) begin
            if (c == 10) btn_lap = 0;
            cyc();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL lap_release c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
            if (!frozen && ones_live == 4'hf) ones_live = s_ones;
        end
        vectors++;
        if (ones_live !== 4'd9) begin
            miscompares++;
            $display("FAIL lap_live_show got=%0d exp=9", ones_live);
        end
    endtask

    task automatic test_stop_resume();
        int t_run, t_tick;
        do_reset();
        btn_ss = 1;
        for (int c = 0; c < 300 && !(m_mode == M_RUN && m_secs >= 1 && m_phase == 7); c++) begin
            if (c == 10) btn_ss = 0;
            cyc();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL stop_wait c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
        end
        btn_ss = 1;
        for (int c = 0; c < 60; c++) begin
            if (c == 10) btn_ss = 0;
            cyc();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL stop_pause c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
        end
        vectors++;
        if (running !== 1'b0) begin
            miscompares++;
            $display("FAIL stop_state running got=%b exp=0", running);
        end
        btn_ss = 1;
        t_run = -1; t_tick = -1;
        for (int c = 0; c < 30; c++) begin
            if (c == 10) btn_ss = 0;
            cyc();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL resume c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
            if (running && t_run < 0) t_run = c;
            if (tick && t_run >= 0 && t_tick < 0) t_tick = c;
        end
        vectors++;
        if (t_run < 0 || t_tick - t_run !== 6) begin
            miscompares++;
            $display("FAIL resume_tick_delay got=%0d exp=6", t_tick - t_run);
        end
        btn_ss = 1;
        for (int c = 0; c < 40; c++) begin
            if (c == 10) btn_ss = 0;
            if (c == 20) btn_lap = 1;
            if (c == 30) btn_lap = 0;
            cyc();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL clear c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
        end
        vectors++;
        if (dut_vec !== 18'd0) begin
            miscompares++;
            $display("FAIL clear_idle got=%h exp=%h", dut_vec, 18'd0);
        end
    endtask

    task automatic test_bounce();
        logic r0;
        int changes;
        logic prev;
        do_reset();
        btn_ss = 1;
        for (int c = 0; c < 20; c++) begin
            if (c == 10) btn_ss = 0;
            cyc();
        end
        r0 = running;
        prev = running;
        changes = 0;
        for (int c = 0; c < 15; c++) begin
            btn_ss = (c < 3) ? ((c % 2) == 0) : 1'b0;
            cyc();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL bounce c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
            if (running !== prev) changes++;
            prev = running;
        end
        vectors++;
        if (changes !== 0 || running !== r0 || r0 !== 1'b1) begin
            miscompares++;
            $display("FAIL bounce_no_event changes=%0d running=%b exp changes=0 running=1", changes, running);
        end
        for (int c = 0; c < 20; c++) begin
            btn_ss = (c < D + 2);
            cyc();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL clean_hold c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
            if (running !== prev) changes++;
            prev = running;
        end
        vectors++;
        if (changes !== 1 || running !== 1'b0) begin
            miscompares++;
            $display("FAIL clean_one_event changes=%0d running=%b exp changes=1 running=0", changes, running);
        end
    endtask

    task automatic test_rollover();
        do_reset();
        btn_ss = 1;
        for (int c = 0; c < 800 && m_secs != 60; c++) begin
            if (c == 10) btn_ss = 0;
            cyc();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL roll_01 c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
        end
        btn_ss = 0;
        vectors++;
        if ({m_tens, m_ones, s_tens, s_ones} !== {4'd0, 4'd1, 3'd0, 4'd0}) begin
            miscompares++;
            $display("FAIL roll_minute got=%h exp=%h", {m_tens, m_ones, s_tens, s_ones}, {4'd0, 4'd1, 3'd0, 4'd0});
        end
        for (int c = 0; c < 62000 && m_secs != 5999; c++) begin
            cyc();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL roll_long c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
        end
        vectors++;
        if ({m_tens, m_ones, s_tens, s_ones} !== {4'd9, 4'd9, 3'd5, 4'd9}) begin
            miscompares++;
            $display("FAIL roll_9959 got=%h exp=%h", {m_tens, m_ones, s_tens, s_ones}, {4'd9, 4'd9, 3'd5, 4'd9});
        end
        for (int c = 0; c < 2 * P && m_secs != 0; c++) begin
            cyc();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL roll_wrap c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
        end
        vectors++;
        if ({running, m_tens, m_ones, s_tens, s_ones} !== {1'b1, 15'd0}) begin
            miscompares++;
            $display("FAIL roll_0000 got=%b_%h exp=1_0000", running, {m_tens, m_ones, s_tens, s_ones});
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        btn_ss = 1;
        for (int c = 0; c < 40; c++) begin
            if (c == 10) btn_ss = 0;
            if (c == 25) begin btn_ss = 1; btn_lap = 1; end
            cyc();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL simul c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
        end
        btn_ss = 0; btn_lap = 0;
        vectors++;
        if ({running, frozen} !== 2'b00) begin
            miscompares++;
            $display("FAIL simul_stop got=%b%b exp=00", running, frozen);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        btn_ss = 1;
        for (int c = 0; c < 300 && m_secs != 3; c++) begin
            if (c == 10) btn_ss = 0;
            cyc();
        end
        btn_ss = 0;
        #2 rst = 1;
        #1;
        vectors++;
        if (dut_vec !== 18'd0) begin
            miscompares++;
            $display("FAIL reset_mid got=%h exp=%h", dut_vec, 18'd0);
        end
        model_reset();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_random();
        int kind, hold, gap;
        do_reset();
        for (int s = 0; s < 40; s++) begin
            kind = $urandom_range(0, 9);
            hold = $urandom_range(1, 12);
            gap  = $urandom_range(1, 40);
            btn_ss  = (kind <= 4) || (kind == 9);
            btn_lap = (kind >= 5);
            for (int c = 0; c < hold + gap; c++) begin
                if (c == hold) begin btn_ss = 0; btn_lap = 0; end
                cyc();
                vectors++;
                if (dut_vec !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL random s=%0d c=%0d got=%h exp=%h", s, c, dut_vec, exp_vec());
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_start();
        test_lap();
        test_stop_resume();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        test_random();
        test_rollover();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Button-driven stopwatch front end that produces the BCD minutes/seconds digits consumed by the display multiplexer stage. It synchronises and debounces two push-buttons, runs a start/stop/lap/clear state machine, divides CLK down to a one-second enable, and keeps a BCD mm:ss count. The digit outputs keep the port widths and digit order already used by the multiplexer, so the block drops in directly upstream of it.

## Interface
- PRESCALE, default 10: CLK cycles per counted second. Range 2..1023.
- DEBOUNCE, default 4: consecutive stable synchronised samples needed to accept a button level change. Range 1..255.
- CLK  in  1  single clock; all state on rising edge.
- RST  in  1  reset, asynchronous and active-high; clears all state.
- BTN_SS  in  1  start/stop button, active-high, asynchronous to CLK.
- BTN_LAP  in  1  lap/clear button, active-high, asynchronous to CLK.
- S_ONES  out  4  displayed seconds ones, BCD 0..9.
- S_TENS  out  3  displayed seconds tens, BCD 0..5.
- M_ONES  out  4  displayed minutes ones, BCD 0..9.
- M_TENS  out  4  displayed minutes tens, BCD 0..9.
- RUNNING  out  1  high in RUN and LAP.
- FROZEN  out  1  high in LAP (display latched).
- TICK  out  1  one-cycle pulse on every seconds increment.

## Operation
- Input path per button: 2-flop synchroniser, then debouncer. The accepted level changes only after DEBOUNCE consecutive equal synchronised samples that differ from it. A press event is a one-cycle pulse on the accepted level's 0->1 edge. Releases generate no event.
- States: IDLE (count 00:00, stopped), RUN, STOP (paused, count kept), LAP (counting, display frozen).
- Transitions on press events:
  - IDLE: SS -> RUN. LAP is ignored.
  - RUN: SS -> STOP. LAP -> LAP and latches the current count into the display register.
  - LAP: LAP -> RUN, display goes live. SS -> STOP, display goes live and shows the live count.
  - STOP: SS -> RUN. LAP -> IDLE and clears both the count and the prescaler.
- Simultaneous SS and LAP events in one cycle: SS wins and LAP is discarded.
- Prescaler counts 0..PRESCALE-1 only in RUN or LAP. It holds its value in STOP, so a resume continues the partial second. TICK is asserted when the prescaler equals PRESCALE-1 while counting. The prescaler then wraps to 0.
- BCD count on TICK: seconds 00..59, then minutes increment. Minutes run 00..99. 99:59 wraps to 00:00 and the state stays RUN/LAP. No digit ever leaves its legal range.
- Display outputs equal the live count, except in LAP, where they equal the latched count.

## Timing
- Reset values:
  - All digits 0.
  - RUNNING=0, FROZEN=0, TICK=0.
  - State IDLE, prescaler 0, synchronisers and debouncers 0.
- Reset mid-operation: immediate asynchronous return to the values above. A button held through reset release is seen as a fresh press once it is debounced.
- Button edge to event pulse: 2 sync cycles plus DEBOUNCE cycles, ±1 cycle for the asynchronous edge.
- Event to state change: the state register updates on the next CLK edge, and RUNNING/FROZEN follow in the same cycle.
- First TICK after IDLE->RUN: PRESCALE cycles after the state change.
- TICK to digit update: digits change on the same edge that ends the TICK cycle. Outputs are registered, with no combinational path from the buttons.
- An SS event in the same cycle as TICK: the increment is applied and then the state stops.

## Structure
- Shared package: state enum (IDLE, RUN, STOP, LAP), BCD limits (SEC_TENS_MAX=5, DIGIT_MAX=9), parameter defaults.
- One sub-module, btn_debounce (synchroniser, debounce counter, edge pulse), instantiated twice. The FSM, prescaler and BCD counter live in the top level.

## Test plan
- Reset, then press SS (held 10 cycles) with PRESCALE=10 -> RUNNING=1. The first TICK arrives 10 cycles after the state change, and S_ONES reads 1.
- Bounce BTN_SS 0/1 every cycle for 3 cycles, then hold it low -> no event and state unchanged. A clean hold of ≥ DEBOUNCE+2 cycles -> exactly one event.
- Run to 00:59 and let one TICK pass -> 01:00. Preload to 99:59 by running long enough -> next TICK gives 00:00 with RUNNING still 1.
- In RUN at 00:05, press LAP -> FROZEN=1 and outputs hold 00:05 while TICK continues. Press LAP again at live count 00:09 -> outputs show 00:09.
- SS stop at prescaler 4, wait 50 cycles, SS again -> the next TICK arrives 6 cycles after RUN re-entry. Then SS stop followed by LAP -> IDLE with 00:00.
- Assert SS and LAP events in the same cycle from RUN -> STOP with FROZEN=0. Assert RST mid-count -> all outputs 0 immediately and the state is IDLE.
